// File: rtl/stc0_twiddle_sram_arb_pkg.sv
// Shared definitions for the twiddle SRAM arbiter: grant encoding,
// default starvation limit and a saturating counter helper.
package stc0_twiddle_sram_arb_pkg;

  // Which requester owns the SRAM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } arb_gnt_e;

  // Lost-arbitration cycles a queued host write tolerates before it is forced.
  localparam int unsigned STC0_STARVE_LIMIT_DEFAULT = 8;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/stc0_sync_fifo.sv
// Generic single-clock FIFO with registered head. DEPTH must be a power of 2.
// Push is ignored when full and pop is ignored when empty; both may happen
// in the same cycle. A pushed entry shows up at the head on the next cycle.
module stc0_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0] CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0] CNT_MAX = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/stc0_twiddle_sram_arb.sv
// Twiddle SPRAM arbiter: butterfly reads win, host writes are queued in a
// small FIFO and forced through after STARVE_LIMIT consecutive lost cycles.
// Optional statistics (ConflictCnt/ForceCnt) under STC0_TWARB_STATS_EN.
module stc0_twiddle_sram_arb
  import stc0_twiddle_sram_arb_pkg::*;
#(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 7,
  parameter int unsigned WFIFO_DEPTH  = 4,
  parameter int unsigned STARVE_LIMIT = STC0_STARVE_LIMIT_DEFAULT
) (
  input  logic          Clk,
  input  logic          ARstn,
  input  logic [AW-1:0] HWAddr,
  input  logic [DW-1:0] HWData,
  input  logic          HWValid,
  output logic          HWReady,
  input  logic          BRdReq,
  input  logic [AW-1:0] BRdAddr,
  output logic          BRdGnt,
  output logic [DW-1:0] BRdData,
  output logic          BRdValid,
  output logic          Csb,
  output logic          Web,
  output logic [AW-1:0] SAddr,
  output logic [DW-1:0] SDin,
  input  logic [DW-1:0] SDout,
  output logic          Busy
`ifdef STC0_TWARB_STATS_EN
  ,
  output logic [15:0]   ConflictCnt,
  output logic [15:0]   ForceCnt
`endif
);

  // Handshake: a host write is accepted on a cycle with HWValid && HWReady;
  // a butterfly read is issued on a cycle with BRdReq && BRdGnt, and a
  // denied read must be held by the requester until granted.

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  logic             run_q;
  logic [SW-1:0]    starve_q, starve_d;
  logic [AW-1:0]    saddr_q, saddr_d;
  logic [DW-1:0]    sdin_q, sdin_d;
  logic             rvalid_q;
  arb_gnt_e         gnt;

  logic             fifo_full;
  logic             fifo_empty;
  logic [AW+DW-1:0] fifo_head;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic             push_w;
  logic             pop_w;
  logic             busy_w;
  logic             force_w;

  // run_q holds HWReady and arbitration off until the first edge after reset.
  assign HWReady   = run_q && !fifo_full;
  assign push_w    = HWValid && HWReady;
  assign pop_w     = (gnt == GNT_WRITE);
  assign busy_w    = !fifo_empty;
  assign force_w   = (starve_q == STARVE_MAX);
  assign head_addr = fifo_head[AW+DW-1:DW];
  assign head_data = fifo_head[DW-1:0];

  stc0_sync_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk_i   (Clk),
    .rst_ni  (ARstn),
    .push_i  (push_w),
    .wdata_i ({HWAddr, HWData}),
    .pop_i   (pop_w),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Grant decision: reads first unless a starved write is pending.
  always_comb begin
    gnt = GNT_IDLE;
    if (run_q) begin
      if (BRdReq && !(force_w && busy_w)) gnt = GNT_READ;
      else if (busy_w)                    gnt = GNT_WRITE;
    end
  end

  // SRAM port drive; address/data hold their last values while idle.
  always_comb begin
    saddr_d = saddr_q;
    sdin_d  = sdin_q;
    case (gnt)
      GNT_READ:  saddr_d = BRdAddr;
      GNT_WRITE: begin
        saddr_d = head_addr;
        sdin_d  = head_data;
      end
      default: ;
    endcase
  end

  assign Csb      = (gnt == GNT_IDLE);
  assign Web      = (gnt != GNT_WRITE);
  assign BRdGnt   = (gnt == GNT_READ);
  assign SAddr    = saddr_d;
  assign SDin     = sdin_d;
  assign BRdValid = rvalid_q;
  assign BRdData  = SDout;
  assign Busy     = busy_w;

  // Starvation count: grows while a write waits behind reads, clears on a
  // write issue or when nothing is queued.
  always_comb begin
    starve_d = starve_q;
    if (pop_w || !busy_w)                   starve_d = '0;
    else if (BRdGnt && !force_w)            starve_d = starve_q + STARVE_ONE;
  end

  // Control and port-holding registers.
  always_ff @(posedge Clk or negedge ARstn) begin
    if (!ARstn) begin
      run_q    <= 1'b0;
      starve_q <= '0;
      saddr_q  <= '0;
      sdin_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      starve_q <= starve_d;
      saddr_q  <= saddr_d;
      sdin_q   <= sdin_d;
      rvalid_q <= BRdGnt;
    end
  end

`ifdef STC0_TWARB_STATS_EN
  logic [15:0] conflict_q;
  logic [15:0] force_q;
  logic        conflict_w;
  logic        forced_w;

  assign conflict_w  = run_q && BRdReq && busy_w;
  assign forced_w    = pop_w && force_w && BRdReq;
  assign ConflictCnt = conflict_q;
  assign ForceCnt    = force_q;

  // Saturating contention and forced-write counters.
  always_ff @(posedge Clk or negedge ARstn) begin
    if (!ARstn) begin
      conflict_q <= '0;
      force_q    <= '0;
    end else begin
      if (conflict_w) conflict_q <= sat_inc16(conflict_q);
      if (forced_w)   force_q    <= sat_inc16(force_q);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_stc0_twiddle_sram_arb.sv
// Bench for stc0_twiddle_sram_arb: queue-based reference model checked at
// every falling edge, directed scenarios with literal expectations, then
// randomized read/write traffic.
module tb_stc0_twiddle_sram_arb;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          Clk = 1'b0;
  logic          ARstn;
  logic [AW-1:0] HWAddr;
  logic [DW-1:0] HWData;
  logic          HWValid;
  logic          HWReady;
  logic          BRdReq;
  logic [AW-1:0] BRdAddr;
  logic          BRdGnt;
  logic [DW-1:0] BRdData;
  logic          BRdValid;
  logic          Csb;
  logic          Web;
  logic [AW-1:0] SAddr;
  logic [DW-1:0] SDin;
  logic [DW-1:0] SDout;
  logic          Busy;
`ifdef STC0_TWARB_STATS_EN
  logic [15:0]   ConflictCnt;
  logic [15:0]   ForceCnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // clock
  always #5 Clk = ~Clk;

  stc0_twiddle_sram_arb #(
    .DW (DW), .AW (AW), .WFIFO_DEPTH (DEPTH), .STARVE_LIMIT (LIMIT)
  ) dut (
    .Clk      (Clk),
    .ARstn    (ARstn),
    .HWAddr   (HWAddr),
    .HWData   (HWData),
    .HWValid  (HWValid),
    .HWReady  (HWReady),
    .BRdReq   (BRdReq),
    .BRdAddr  (BRdAddr),
    .BRdGnt   (BRdGnt),
    .BRdData  (BRdData),
    .BRdValid (BRdValid),
    .Csb      (Csb),
    .Web      (Web),
    .SAddr    (SAddr),
    .SDin     (SDin),
    .SDout    (SDout),
    .Busy     (Busy)
`ifdef STC0_TWARB_STATS_EN
    ,
    .ConflictCnt (ConflictCnt),
    .ForceCnt    (ForceCnt)
`endif
  );

  // single-port SRAM with one-cycle registered read
  logic [DW-1:0] sram [1<<AW];
  always @(posedge Clk) begin
    if (!Csb) begin
      if (!Web) sram[SAddr] <= SDin;
      else      SDout <= sram[SAddr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] exp_mem [1<<AW];
  int            starve;
  bit            m_run;
  bit            pend_v;
  logic [DW-1:0] pend_d;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_d;
  int            m_conf;
  int            m_force;

  // compare process: outputs are checked against the model at every
  // falling edge, then the model advances to the state after the next rise
  always @(negedge Clk) begin : cmp_p
    bit            busy, full, frc, rd, wr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (!ARstn) begin
      wq.delete();
      starve = 0; m_run = 0; pend_v = 0; last_a = '0; last_d = '0;
      m_conf = 0; m_force = 0;
      chk("rst_hwready", HWReady, 0);
      chk("rst_csb", Csb, 1);
      chk("rst_web", Web, 1);
      chk("rst_gnt", BRdGnt, 0);
      chk("rst_valid", BRdValid, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_saddr", SAddr, 0);
      chk("rst_sdin", SDin, 0);
    end else begin
      busy = (wq.size() != 0);
      full = (wq.size() == DEPTH);
      frc  = (starve == LIMIT);
      rd   = m_run && BRdReq && !(frc && busy);
      wr   = m_run && !rd && busy;
      ea   = rd ? BRdAddr : (wr ? wq[0].a : last_a);
      ed   = wr ? wq[0].d : last_d;
      chk("hwready", HWReady, m_run && !full);
      chk("busy", Busy, busy);
      chk("gnt", BRdGnt, rd);
      chk("csb", Csb, !(rd || wr));
      chk("web", Web, !wr);
      chk("saddr", SAddr, ea);
      chk("sdin", SDin, ed);
      chk("rvalid", BRdValid, pend_v);
      if (pend_v) chk("rdata", BRdData, pend_d);
`ifdef STC0_TWARB_STATS_EN
      chk("conflict_cnt", ConflictCnt, m_conf);
      chk("force_cnt", ForceCnt, m_force);
      if (m_run && BRdReq && busy) m_conf++;
      if (wr && frc && BRdReq) m_force++;
`endif
      if (wr) begin
        exp_mem[wq[0].a] = wq[0].d;
        last_d = wq[0].d;
      end
      last_a = ea;
      pend_v = rd;
      if (rd) pend_d = exp_mem[BRdAddr];
      if (wr || !busy) starve = 0;
      else if (rd && starve < LIMIT) starve++;
      if (wr) void'(wq.pop_front());
      if (m_run && HWValid && !full) wq.push_back(wr_t'({HWAddr, HWData}));
      m_run = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mid(); #5; endtask
  task automatic adv(); @(posedge Clk); #1; endtask

  task automatic host(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    HWValid = v; HWAddr = a; HWData = d;
  endtask

  int acc_c;
  bit acc_w, den_r;
  int p_rd, p_wr;

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      sram[i]    = '0;
      exp_mem[i] = '0;
    end
    ARstn = 1'b0; BRdReq = 1'b0; BRdAddr = '0;
    host(1'b0, '0, '0);
    repeat (3) @(posedge Clk);
    #1;
    chk("lit_rst_ready", HWReady, 0);
    chk("lit_rst_csb", Csb, 1);
    ARstn = 1'b1;
    mid(); chk("lit_ready_pre_edge", HWReady, 0);
    adv(); mid(); chk("lit_ready_post_edge", HWReady, 1);
    adv();

    // three host writes, no reads
    host(1'b1, 7'h05, 32'hA5A50001); mid(); chk("t1_idle_csb", Csb, 1); adv();
    host(1'b1, 7'h06, 32'hA5A50002); mid();
    chk("t1_w0_web", Web, 0); chk("t1_w0_addr", SAddr, 7'h05); chk("t1_w0_data", SDin, 32'hA5A50001); adv();
    host(1'b1, 7'h07, 32'hA5A50003); mid(); chk("t1_w1_addr", SAddr, 7'h06); adv();
    host(1'b0, '0, '0); mid(); chk("t1_w2_addr", SAddr, 7'h07); chk("t1_w2_busy", Busy, 1); adv();
    mid(); chk("t1_done_busy", Busy, 0); chk("t1_done_csb", Csb, 1); adv();

    // write then read back
    host(1'b1, 7'h10, 32'h12345678); mid(); adv();
    host(1'b0, '0, '0); mid(); chk("t2_wr_web", Web, 0); chk("t2_wr_addr", SAddr, 7'h10); adv();
    BRdReq = 1'b1; BRdAddr = 7'h10; mid();
    chk("t2_rd_gnt", BRdGnt, 1); chk("t2_rd_csb", Csb, 0); chk("t2_rd_web", Web, 1); adv();
    BRdReq = 1'b0; mid(); chk("t2_rd_valid", BRdValid, 1); chk("t2_rd_data", BRdData, 32'h12345678); adv();

    // starvation force with reads held high (fresh reset clears statistics)
    ARstn = 1'b0; adv(); ARstn = 1'b1; adv();
    BRdReq = 1'b1; BRdAddr = 7'h03; host(1'b1, 7'h20, 32'hCAFE0001);
    mid(); chk("t3_c0_gnt", BRdGnt, 1); adv();
    host(1'b0, '0, '0);
    for (int i = 1; i <= 8; i++) begin
      mid(); chk("t3_read_gnt", BRdGnt, 1); adv();
    end
    mid(); chk("t3_force_gnt", BRdGnt, 0); chk("t3_force_web", Web, 0); chk("t3_force_addr", SAddr, 7'h20); adv();
    mid(); chk("t3_resume_gnt", BRdGnt, 1); chk("t3_resume_busy", Busy, 0);
`ifdef STC0_TWARB_STATS_EN
    chk("t3_force_cnt", ForceCnt, 1);
    chk("t3_conflict_cnt", ConflictCnt, 9);
`endif
    adv();
    BRdReq = 1'b0; adv();

    // fill FIFO behind reads; fifth write waits for the forced pop
    BRdReq = 1'b1; BRdAddr = 7'h05;
    for (int i = 0; i < 4; i++) begin
      host(1'b1, 7'(8'h40 + i), 32'hF0000000 + i); mid(); adv();
    end
    host(1'b1, 7'h44, 32'hF0000004);
    mid(); chk("t4_full_ready", HWReady, 0);
    acc_c = -1;
    for (int c = 4; c < 20; c++) begin
      if (c > 4) mid();
      if (c == 9) chk("t4_force_web", Web, 0);
      if (HWReady && acc_c < 0) acc_c = c;
      adv();
      if (acc_c >= 0) break;
    end
    chk("t4_accept_cycle", acc_c, 10);
    host(1'b0, '0, '0); BRdReq = 1'b0;
    repeat (8) begin mid(); adv(); end

    // reset with writes queued and a read in flight
    BRdReq = 1'b1; BRdAddr = 7'h04;
    host(1'b1, 7'h50, 32'hDEAD0001); mid(); adv();
    host(1'b1, 7'h51, 32'hDEAD0002); mid(); adv();
    host(1'b0, '0, '0); mid(); chk("t5_rd_gnt", BRdGnt, 1); adv();
    ARstn = 1'b0; #1;
    chk("t5_squash_valid", BRdValid, 0); chk("t5_busy", Busy, 0); chk("t5_csb", Csb, 1);
    BRdReq = 1'b0; adv(); adv();
    ARstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mid(); chk("t5_no_write", Web, 1); adv();
    end

    // randomized traffic in phases of differing contention
    for (int ph = 0; ph < 6; ph++) begin
      p_rd = $urandom_range(10, 95);
      p_wr = $urandom_range(10, 90);
      for (int n = 0; n < 400; n++) begin
        if (!(HWValid && !acc_w) || n == 0)
          host($urandom_range(0, 99) < p_wr, 7'($urandom_range(0, 15)), $urandom);
        if (!den_r || n == 0) begin
          BRdReq  = ($urandom_range(0, 99) < p_rd);
          BRdAddr = 7'($urandom_range(0, 15));
        end
        mid();
        acc_w = HWValid && HWReady;
        den_r = BRdReq && !BRdGnt;
        adv();
      end
    end
    host(1'b0, '0, '0); BRdReq = 1'b0;
    repeat (10) begin mid(); adv(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
